// File: rtl/riscv_isa_pkg.sv
// ISA-level widths shared by the front end: address and instruction sizes.
package riscv_isa_pkg;

    // Virtual address width seen by the fetch path.
    localparam int CPU_ADDR_BITS = 32;

    // Width of one fixed-length instruction slot.
    localparam int CPU_INST_BITS = 32;

endpackage

// File: rtl/uarch_pkg.sv
// Micro-architecture parameters and types for the front end: fetch packet
// geometry, the fetch FSM state encoding and the packet alignment helper.
package uarch_pkg;

    import riscv_isa_pkg::*;

    // Instructions per fetch packet; slot 0 lives in the low bits.
    localparam int FETCH_WIDTH = 2;

    // Packet width in bits and in bytes (the fetch_pc stride).
    localparam int          FETCH_BITS  = FETCH_WIDTH * CPU_INST_BITS;
    localparam int unsigned FETCH_BYTES = FETCH_BITS / 8;

    // Fetch FSM states:
    //   FETCH  - may issue a request for fetch_pc
    //   WAIT   - one request outstanding, response will be kept
    //   SQUASH - one request outstanding, response will be thrown away
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    // Force an address onto an 8-byte fetch-packet boundary.
    function automatic logic [CPU_ADDR_BITS-1:0] align_fetch_pc(
        input logic [CPU_ADDR_BITS-1:0] addr
    );
        return {addr[CPU_ADDR_BITS-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks fetch_pc through memory one 8-byte packet at
// a time, keeps a single ICache request in flight, and hands each returned
// packet to the instruction buffer through a one-entry output register.
// A flush redirects fetch_pc and squashes whatever is in flight.
//
// Handshakes (both directions): a transfer happens on a rising clk edge where
// valid && ready are both 1. The sender never withdraws or changes a valid
// beat until it is taken; the ICache response is a one-cycle strobe with no
// backpressure, which is safe because at most one request is ever
// outstanding and the output register is always empty when it returns.
module fetch_unit
    import riscv_isa_pkg::*;
    import uarch_pkg::*;
#(
    // First fetch address after reset; must be 8-byte aligned.
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [CPU_ADDR_BITS-1:0]             redirect_pc,
    output logic [CPU_ADDR_BITS-1:0]             icache_req_addr,
    output logic                                 icache_req_val,
    input  logic                                 icache_req_rdy,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_resp_data,
    input  logic                                 icache_resp_val,
    output logic [CPU_ADDR_BITS-1:0]             pc,
    output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout,
    output logic                                 icache_dout_val,
    input  logic                                 inst_buffer_rdy,
    output fetch_state_t                         dbg_state
);

    // FSM state and fetch address.
    fetch_state_t                         state_q;
    logic [CPU_ADDR_BITS-1:0]             fetch_pc_q;

    // One-entry output register feeding the instruction buffer.
    logic                                 out_val_q;
    logic [CPU_ADDR_BITS-1:0]             out_pc_q;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] out_data_q;

    // Next sequential packet address; the add wraps naturally at the top of
    // the address space.
    logic [CPU_ADDR_BITS-1:0]             seq_pc_d;

    // The output register will be empty at the next edge: either it already
    // is, or the instruction buffer is taking its packet this cycle.
    logic                                 out_free;
    logic                                 out_drain;
    logic                                 req_fire;

    assign seq_pc_d  = fetch_pc_q + CPU_ADDR_BITS'(FETCH_BYTES);
    assign out_drain = out_val_q && inst_buffer_rdy;
    assign out_free  = !out_val_q || inst_buffer_rdy;

    // A request is only offered when its response is guaranteed a home, so
    // the no-backpressure response can always be captured. Reset and flush
    // both suppress the request combinationally.
    assign icache_req_val  = rst && !flush && (state_q == FETCH) && out_free;
    assign icache_req_addr = fetch_pc_q;
    assign req_fire        = icache_req_val && icache_req_rdy;

    assign pc              = out_pc_q;
    assign icache_dout     = out_data_q;
    assign icache_dout_val = out_val_q;
    assign dbg_state       = state_q;

    // Fetch FSM together with fetch_pc and the output register; reset first,
    // then flush, then normal request/response/drain traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // A request left in flight by WAIT may still be answered right
            // after reset; SQUASH makes sure that answer is discarded.
            state_q    <= (state_q == WAIT) ? SQUASH : FETCH;
            fetch_pc_q <= RESET_PC;
            out_val_q  <= 1'b0;
            out_pc_q   <= '0;
            out_data_q <= '0;
        end else if (flush) begin
            fetch_pc_q <= align_fetch_pc(redirect_pc);
            out_val_q  <= 1'b0;
            case (state_q)
                // Still waiting on the old request: squash it, unless it is
                // returning right now, in which case it is simply dropped.
                WAIT:    state_q <= icache_resp_val ? FETCH : SQUASH;
                // Stay in SQUASH until the stale response shows up; if it
                // shows up in this very cycle it is gone, so resume fetching.
                SQUASH:  state_q <= icache_resp_val ? FETCH : SQUASH;
                default: state_q <= FETCH;
            endcase
        end else begin
            if (out_drain) begin
                out_val_q <= 1'b0;
            end
            case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // The output register was emptied when the request was
                    // issued, so the capture never overwrites a live packet.
                    if (icache_resp_val) begin
                        out_val_q  <= 1'b1;
                        out_pc_q   <= fetch_pc_q;
                        out_data_q <= icache_resp_data;
                        fetch_pc_q <= seq_pc_d;
                        state_q    <= FETCH;
                    end
                end
                SQUASH: begin
                    if (icache_resp_val) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-request ICache model with a
// programmable response delay, directed stimulus for streaming, stall,
// redirect, wrap-around and reset-during-WAIT, and a packet scoreboard.
module tb_fetch_unit;

    import riscv_isa_pkg::*;
    import uarch_pkg::*;

    localparam logic [CPU_ADDR_BITS-1:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic                                 clk;
    logic                                 rst;
    logic                                 flush;
    logic [CPU_ADDR_BITS-1:0]             redirect_pc;
    logic [CPU_ADDR_BITS-1:0]             icache_req_addr;
    logic                                 icache_req_val;
    logic                                 icache_req_rdy;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_resp_data;
    logic                                 icache_resp_val;
    logic [CPU_ADDR_BITS-1:0]             pc;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout;
    logic                                 icache_dout_val;
    logic                                 inst_buffer_rdy;
    fetch_state_t                         dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .icache_req_addr  (icache_req_addr),
        .icache_req_val   (icache_req_val),
        .icache_req_rdy   (icache_req_rdy),
        .icache_resp_data (icache_resp_data),
        .icache_resp_val  (icache_resp_val),
        .pc               (pc),
        .icache_dout      (icache_dout),
        .icache_dout_val  (icache_dout_val),
        .inst_buffer_rdy  (inst_buffer_rdy),
        .dbg_state        (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int resp_delay = 1;
    logic [CPU_ADDR_BITS-1:0] exp_q[$];

    // Packet contents the ICache model returns for a given address.
    function automatic logic [FETCH_WIDTH*CPU_INST_BITS-1:0] pkt_data(
        input logic [CPU_ADDR_BITS-1:0] a
    );
        return {a ^ 32'h2468_ACE0, a ^ 32'h1357_9BDF};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound(input string name, input int t, input int lim);
        n_checks++;
        if (t >= lim) begin
            n_fail++;
            $display("FAIL %s: waited %0d cycles, limit %0d", name, t, lim);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- ICache model ----------------
    // Samples acceptance at the falling edge and answers resp_delay cycles
    // after the accepting edge with a one-cycle strobe.
    initial begin : icache_model
        logic                     acc;
        logic [CPU_ADDR_BITS-1:0] acc_addr;
        logic [CPU_ADDR_BITS-1:0] pend;
        int                       cnt;
        icache_resp_val  = 1'b0;
        icache_resp_data = '0;
        cnt  = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            acc      = icache_req_val && icache_req_rdy;
            acc_addr = icache_req_addr;
            @(posedge clk);
            #1;
            icache_resp_val = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    icache_resp_val  = 1'b1;
                    icache_resp_data = pkt_data(pend);
                end
            end
            if (acc) begin
                pend = acc_addr;
                if (resp_delay <= 1) begin
                    icache_resp_val  = 1'b1;
                    icache_resp_data = pkt_data(pend);
                end else begin
                    cnt = resp_delay - 1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic                                 held;
        logic [CPU_ADDR_BITS-1:0]             hpc;
        logic [FETCH_WIDTH*CPU_INST_BITS-1:0] hdata;
        logic [CPU_ADDR_BITS-1:0]             e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (held) begin
                check("hold_val", 64'(icache_dout_val), 64'(1'b1));
                check("hold_pc", 64'(pc), 64'(hpc));
                check("hold_data", icache_dout, hdata);
            end
            held = 1'b0;
            if (icache_dout_val == 1'b1) begin
                if (inst_buffer_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_packet: got pc 0x%0h, expected no packet", pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pkt_pc", 64'(pc), 64'(e));
                        check("pkt_data", icache_dout, pkt_data(e));
                    end
                end else begin
                    held  = 1'b1;
                    hpc   = pc;
                    hdata = icache_dout;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        int t;
        rst             = 1'b0;
        flush           = 1'b0;
        redirect_pc     = '0;
        icache_req_rdy  = 1'b1;
        inst_buffer_rdy = 1'b1;

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        check("rst_req_val", 64'(icache_req_val), 64'(1'b0));
        check("rst_dout_val", 64'(icache_dout_val), 64'(1'b0));
        check("rst_pc", 64'(pc), 64'(0));
        check("rst_dout", icache_dout, 64'(0));
        check("rst_state", 64'(dbg_state), 64'(FETCH));

        // Streaming from RESET_PC: request in the first cycle out of reset,
        // packet two cycles later, next packet two cycles after that.
        step();
        rst = 1'b1;
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0008);
        @(negedge clk);
        check("first_req_val", 64'(icache_req_val), 64'(1'b1));
        check("first_req_addr", 64'(icache_req_addr), 64'(RESET_PC));
        @(negedge clk);
        check("lat_n1_val", 64'(icache_dout_val), 64'(1'b0));
        @(negedge clk);
        check("lat_n2_val", 64'(icache_dout_val), 64'(1'b1));
        @(negedge clk);
        check("gap_val", 64'(icache_dout_val), 64'(1'b0));

        // Instruction buffer stalls for 5 cycles on the 0x8 packet.
        step();
        inst_buffer_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_val", 64'(icache_req_val), 64'(1'b0));
            check("stall_pc", 64'(pc), 64'(32'h0000_0008));
        end
        step();
        inst_buffer_rdy = 1'b1;
        resp_delay      = 3;

        // Flush while WAIT, stale response arrives later while squashing.
        t = 0;
        do begin
            step();
            t++;
        end while (dbg_state != WAIT && t < 20);
        bound("reach_wait", t, 20);
        flush       = 1'b1;
        redirect_pc = 32'h0000_1234;
        exp_q.push_back(32'h0000_1230);
        @(negedge clk);
        check("flush_req_val", 64'(icache_req_val), 64'(1'b0));
        step();
        flush      = 1'b0;
        resp_delay = 1;
        @(negedge clk);
        check("squash_state", 64'(dbg_state), 64'(SQUASH));
        check("squash_dout_val", 64'(icache_dout_val), 64'(1'b0));
        t = 0;
        while (!icache_req_val && t < 20) begin
            @(negedge clk);
            t++;
        end
        bound("redirect_req", t, 20);
        check("redirect_req_delay", 64'(t), 64'(2));
        check("redirect_req_addr", 64'(icache_req_addr), 64'(32'h0000_1230));

        // Flush in the same cycle as a response; redirect to the top of the
        // address space so the next packets wrap to 0.
        t = 0;
        do begin
            step();
            t++;
        end while (!(exp_q.size() == 0 && dbg_state == WAIT && icache_resp_val) && t < 20);
        bound("reach_resp", t, 20);
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        check("sameflush_req_val", 64'(icache_req_val), 64'(1'b0));
        step();
        flush = 1'b0;
        @(negedge clk);
        check("sameflush_dout_val", 64'(icache_dout_val), 64'(1'b0));
        check("sameflush_req_val_next", 64'(icache_req_val), 64'(1'b1));
        check("sameflush_req_addr", 64'(icache_req_addr), 64'(32'hFFFF_FFF8));

        // Reset asserted while WAIT; the late response lands in SQUASH.
        t = 0;
        do begin
            step();
            t++;
        end while (exp_q.size() != 1 && t < 20);
        bound("reach_one_left", t, 20);
        resp_delay = 2;
        t = 0;
        do begin
            step();
            t++;
        end while (!(exp_q.size() == 0 && dbg_state == WAIT) && t < 20);
        bound("reach_wait_rst", t, 20);
        rst = 1'b0;
        step();
        rst        = 1'b1;
        resp_delay = 1;
        exp_q.push_back(RESET_PC);
        @(negedge clk);
        check("rstwait_state", 64'(dbg_state), 64'(SQUASH));
        check("rstwait_dout_val", 64'(icache_dout_val), 64'(1'b0));
        check("rstwait_pc", 64'(pc), 64'(0));
        check("rstwait_dout", icache_dout, 64'(0));
        check("rstwait_req_val", 64'(icache_req_val), 64'(1'b0));
        @(negedge clk);
        check("rstwait_req_val_next", 64'(icache_req_val), 64'(1'b1));
        check("rstwait_req_addr", 64'(icache_req_addr), 64'(RESET_PC));
        step();
        icache_req_rdy = 1'b0;

        // Drain and idle; any extra packet shows up as unexpected.
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            step();
            t++;
        end
        bound("drain", t, 20);
        repeat (8) step();
        check("leftover", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the run never reaches its end.
    initial begin : watchdog
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset and SHALL be 8-byte aligned.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low; state SHALL be reset on a clk edge while rst==0.
REQ-004 flush  in  1  pipeline redirect strobe.
REQ-005 redirect_pc  in  CPU_ADDR_BITS  redirect target, valid when flush==1.
REQ-006 icache_req_addr  out  CPU_ADDR_BITS  fetch-packet address to ICache.
REQ-007 icache_req_val  out  1  request valid.
REQ-008 icache_req_rdy  in  1  ICache accepts the request when icache_req_val && icache_req_rdy.
REQ-009 icache_resp_data  in  FETCH_WIDTH*CPU_INST_BITS  returned packet, slot 0 in the low bits.
REQ-010 icache_resp_val  in  1  response valid, 1 cycle, no backpressure.
REQ-011 pc  out  CPU_ADDR_BITS  packet address to instruction buffer.
REQ-012 icache_dout  out  FETCH_WIDTH*CPU_INST_BITS  packet to instruction buffer.
REQ-013 icache_dout_val  out  1  packet valid to instruction buffer.
REQ-014 inst_buffer_rdy  in  1  buffer accepts the packet when icache_dout_val && inst_buffer_rdy.

Function
REQ-015 The block SHALL keep at most one ICache request outstanding.
REQ-016 FSM states SHALL be FETCH, WAIT, SQUASH.
REQ-017 FETCH: icache_req_val=1 iff output register empty (or draining this cycle) and flush==0; icache_req_addr=fetch_pc; on acceptance -> WAIT.
REQ-018 WAIT: on icache_resp_val, data and fetch_pc SHALL be captured into output register, fetch_pc <= fetch_pc+8, -> FETCH.
REQ-019 SQUASH: on icache_resp_val the response SHALL be discarded and state -> FETCH; no output update.
REQ-020 Output register SHALL drive pc/icache_dout/icache_dout_val directly (registered outputs, no combinational path from inputs).
REQ-021 Output register SHALL hold stable while icache_dout_val==1 and inst_buffer_rdy==0; it clears on acceptance unless refilled the same cycle.
REQ-022 Latency: request accepted in cycle N with response in N+1 SHALL give icache_dout_val=1 in N+2; peak throughput one packet per two cycles.
REQ-023 fetch_pc addition SHALL wrap modulo 2^CPU_ADDR_BITS (0xFFFF_FFF8 -> 0x0000_0000).
REQ-024 flush SHALL have priority over all other events: fetch_pc <= {redirect_pc[CPU_ADDR_BITS-1:3],3'b000}, output register valid cleared.
REQ-025 flush in WAIT without same-cycle icache_resp_val -> SQUASH; with same-cycle icache_resp_val -> response dropped, -> FETCH.
REQ-026 flush in FETCH or SQUASH -> FETCH / SQUASH respectively (no request issued in the flush cycle).
REQ-027 The first post-flush request SHALL issue the cycle after flush, addressed to the aligned redirect_pc.

Reset
REQ-028 On reset: state=FETCH, fetch_pc=RESET_PC, icache_dout_val=0, pc=0, icache_dout=0.
REQ-029 icache_req_val SHALL be 0 while rst==0; the first request SHALL issue in the first cycle with rst==1.
REQ-030 Reset during WAIT/SQUASH SHALL abandon the outstanding request; a response arriving the cycle after reset release SHALL be ignored only if state is SQUASH, so reset SHALL enter SQUASH when asserted in WAIT, else FETCH.

Structure
REQ-031 CPU_ADDR_BITS, CPU_INST_BITS, FETCH_WIDTH SHALL come from uarch_pkg/riscv_isa_pkg; the FSM state enum (fetch_state_t) SHALL be added to uarch_pkg.
REQ-032 The block SHALL be flat; no sub-module.

Verification
REQ-033 Reset release, icache_req_rdy=1, 1-cycle ICache, inst_buffer_rdy=1 -> packets at pc 0x0,0x8,0x10 every 2 cycles, first icache_dout_val 2 cycles after release.
REQ-034 inst_buffer_rdy=0 for 5 cycles with packet at 0x8 held -> pc/icache_dout stable, icache_req_val=0, no lost or duplicate packet after rdy returns.
REQ-035 flush with redirect_pc=0x1234 while in WAIT, response 2 cycles later -> stale response dropped, next request addr 0x1230, next delivered pc 0x1230.
REQ-036 flush in the same cycle as icache_resp_val -> response dropped, icache_dout_val=0 next cycle, request to aligned redirect_pc next cycle.
REQ-037 redirect_pc=0xFFFF_FFF8 -> packets at 0xFFFF_FFF8 then 0x0000_0000.
REQ-038 rst=0 asserted mid-WAIT then released -> outputs zero, late response ignored, first delivered pc RESET_PC.
